// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU timer controller: FSM states, register
// addresses and bit positions inside the CTRL and STATUS registers.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } tpu_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_CMP    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_MSK      = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_RSTTPU   = 2;

  localparam int STAT_CLR      = 0;
  localparam int STAT_ACK      = 8;
  localparam int STAT_PEND     = 8;
  localparam int STAT_TIME_LSB = 9;

endpackage

// File: rtl/tpu_irq_fsm.sv
// TPUINT rising-edge detector and the IDLE/PEND/DRAIN interrupt handshake.
// o_take pulses on the edge where an event is accepted into PEND.
module tpu_irq_fsm
  import tpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tpuint,
  input  logic       i_msk,
  input  logic       i_msk_clr,
  input  logic       i_ack,
  output logic       o_take,
  output tpu_state_e o_state,
  output logic       o_irq,
  output logic       o_intflag
);

  logic       r_tpuint_d;
  logic       r_irq;
  logic       r_intflag;
  tpu_state_e r_state;
  tpu_state_e w_next;
  logic       w_rise;

  assign w_rise = i_tpuint & ~r_tpuint_d;

  // A mask clear while pending discards the event rather than acknowledging it.
  always_comb begin
    w_next = r_state;
    o_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && i_msk) begin
          w_next = ST_PEND;
          o_take = 1'b1;
        end
      end
      ST_PEND: begin
        if (i_msk_clr)  w_next = ST_IDLE;
        else if (i_ack) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_tpuint) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tpuint_d <= 1'b0;
      r_state    <= ST_IDLE;
      r_irq      <= 1'b0;
      r_intflag  <= 1'b0;
    end else begin
      r_tpuint_d <= i_tpuint;
      r_state    <= w_next;
      r_irq      <= (w_next == ST_PEND);
      r_intflag  <= (w_next == ST_PEND);
    end
  end

  assign o_state   = r_state;
  assign o_irq     = r_irq;
  assign o_intflag = r_intflag;

endmodule

// File: rtl/tpu_timer_ctrl.sv
// CPU-side TPU timer controller: register bus, compare auto-reload and event
// counter around the interrupt handshake FSM.
module tpu_timer_ctrl
  import tpu_pkg::*;
#(
  parameter int EVT_W  = 8,
  parameter int TIME_W = 7
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              TPUINT,
  input  logic [TIME_W-1:0] TIME,
  input  logic [1:0]        BUS_ADDR,
  input  logic              BUS_WE,
  input  logic              BUS_RE,
  input  logic [15:0]       BUS_WDATA,
  output logic [15:0]       BUS_RDATA,
  output logic              IRQ,
  input  logic              IACK,
  output logic              RSTTPU,
  output logic              TIMERINTMSK,
  output logic              INTFLAG,
  output logic [15:0]       TIMER_INT_VALUE
);

  logic             r_msk;
  logic             r_periodic;
  logic             r_rsttpu;
  logic [15:0]      r_cmp;
  logic [15:0]      r_period;
  logic [EVT_W-1:0] r_evt;
  logic [15:0]      r_rdata;

  logic       w_wr_ctrl, w_wr_cmp, w_wr_per, w_wr_stat;
  logic       w_msk_clr, w_ack, w_evt_clr, w_take;
  logic [15:0] w_rdata;
  tpu_state_e w_state;

  assign w_wr_ctrl = BUS_WE && (BUS_ADDR == ADDR_CTRL);
  assign w_wr_cmp  = BUS_WE && (BUS_ADDR == ADDR_CMP);
  assign w_wr_per  = BUS_WE && (BUS_ADDR == ADDR_PERIOD);
  assign w_wr_stat = BUS_WE && (BUS_ADDR == ADDR_STATUS);

  assign w_msk_clr = w_wr_ctrl & ~BUS_WDATA[CTRL_MSK];
  assign w_ack     = IACK | (w_wr_stat & BUS_WDATA[STAT_ACK]);
  assign w_evt_clr = w_wr_stat & BUS_WDATA[STAT_CLR];

  // Mask seen by the FSM already reflects a clear landing this cycle.
  tpu_irq_fsm u_fsm (
    .i_clk     (SYS_CLK),
    .i_rst     (RST),
    .i_tpuint  (TPUINT),
    .i_msk     (r_msk & ~w_msk_clr),
    .i_msk_clr (w_msk_clr),
    .i_ack     (w_ack),
    .o_take    (w_take),
    .o_state   (w_state),
    .o_irq     (IRQ),
    .o_intflag (INTFLAG)
  );

  always_comb begin
    w_rdata = '0;
    case (BUS_ADDR)
      ADDR_CTRL: begin
        w_rdata[CTRL_MSK]      = r_msk;
        w_rdata[CTRL_PERIODIC] = r_periodic;
      end
      ADDR_CMP:    w_rdata = r_cmp;
      ADDR_PERIOD: w_rdata = r_period;
      default: begin
        w_rdata[7:0]                = 8'(r_evt);
        w_rdata[STAT_PEND]          = (w_state == ST_PEND);
        w_rdata[15:STAT_TIME_LSB]   = 7'(TIME);
      end
    endcase
  end

  // Bus writes take priority over auto-reload and the counter clear over increment.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_msk      <= 1'b0;
      r_periodic <= 1'b0;
      r_rsttpu   <= 1'b0;
      r_cmp      <= '0;
      r_period   <= '0;
      r_evt      <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_msk      <= BUS_WDATA[CTRL_MSK];
        r_periodic <= BUS_WDATA[CTRL_PERIODIC];
      end
      r_rsttpu <= w_wr_ctrl & BUS_WDATA[CTRL_RSTTPU];
      if (w_wr_cmp)                  r_cmp <= BUS_WDATA;
      else if (w_take && r_periodic) r_cmp <= r_cmp + r_period;
      if (w_wr_per) r_period <= BUS_WDATA;
      if (w_evt_clr)   r_evt <= '0;
      else if (w_take) r_evt <= r_evt + EVT_W'(1);
      if (BUS_RE) r_rdata <= w_rdata;
    end
  end

  assign BUS_RDATA       = r_rdata;
  assign RSTTPU          = r_rsttpu;
  assign TIMERINTMSK     = r_msk;
  assign TIMER_INT_VALUE = r_cmp;

endmodule

// File: tb/tb_tpu_timer_ctrl.sv
// Bench for tpu_timer_ctrl: per-feature tasks with inline checks, plus a read
// scoreboard that compares BUS_RDATA against values queued at the strobe.
module tb_tpu_timer_ctrl;
  import tpu_pkg::*;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TPUINT = 1'b0;
  logic [6:0]  TIME = '0;
  logic [1:0]  BUS_ADDR = '0;
  logic        BUS_WE = 1'b0;
  logic        BUS_RE = 1'b0;
  logic [15:0] BUS_WDATA = '0;
  logic [15:0] BUS_RDATA;
  logic        IRQ;
  logic        IACK = 1'b0;
  logic        RSTTPU;
  logic        TIMERINTMSK;
  logic        INTFLAG;
  logic [15:0] TIMER_INT_VALUE;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic        re_d = 1'b0;
  logic [6:0]  tm;
  logic [7:0]  m_evt = '0;
  logic [15:0] m_cmp = '0;

  tpu_timer_ctrl #(.EVT_W(8), .TIME_W(7)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .TPUINT(TPUINT), .TIME(TIME),
    .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .BUS_RE(BUS_RE),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .IRQ(IRQ), .IACK(IACK),
    .RSTTPU(RSTTPU), .TIMERINTMSK(TIMERINTMSK), .INTFLAG(INTFLAG),
    .TIMER_INT_VALUE(TIMER_INT_VALUE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Read data is valid the cycle after the strobe; compare mid-cycle.
  always @(posedge SYS_CLK) re_d <= BUS_RE;

  always @(negedge SYS_CLK) begin
    if (re_d) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: BUS_RDATA=%h with no expected value queued", BUS_RDATA);
      end else begin
        logic [15:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (BUS_RDATA !== e) begin
          n_err++;
          $display("FAIL %s: BUS_RDATA=%h required %h", t, BUS_RDATA, e);
        end
      end
    end
  end

  function automatic logic [15:0] status(input logic pend, input logic [7:0] evt);
    return {tm, pend, evt};
  endfunction

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    BUS_ADDR = a; BUS_WDATA = d; BUS_WE = 1'b1;
    tick();
    BUS_WE = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [15:0] e, input string t);
    BUS_ADDR = a; BUS_RE = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    BUS_RE = 1'b0;
  endtask

  // Timer-like event: TPUINT held until the controller drains, then released.
  task automatic ack_event(input bit via_status);
    TPUINT = 1'b1;
    tick();
    if (via_status) bus_write(ADDR_STATUS, 16'h0100);
    else begin IACK = 1'b1; tick(); IACK = 1'b0; end
    TPUINT = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tm = 7'($urandom_range(0, 127));
    TIME = tm;
    #12;
    n_cmp++; if ({IRQ, INTFLAG, RSTTPU, TIMERINTMSK} !== 4'b0000) begin
      n_err++; $display("FAIL rst_ctl: IRQ/INTFLAG/RSTTPU/MSK=%b required 0000", {IRQ, INTFLAG, RSTTPU, TIMERINTMSK}); end
    n_cmp++; if (TIMER_INT_VALUE !== 16'h0) begin
      n_err++; $display("FAIL rst_cmp: TIMER_INT_VALUE=%h required 0000", TIMER_INT_VALUE); end
    n_cmp++; if (BUS_RDATA !== 16'h0) begin
      n_err++; $display("FAIL rst_rdata: BUS_RDATA=%h required 0000", BUS_RDATA); end
    tick();
    RST = 1'b0;
    tick();
    bus_read(ADDR_CTRL,   16'h0000, "rst_rd_ctrl");
    bus_read(ADDR_CMP,    16'h0000, "rst_rd_cmp");
    bus_read(ADDR_PERIOD, 16'h0000, "rst_rd_period");
    bus_read(ADDR_STATUS, status(1'b0, 8'd0), "rst_rd_status");
  endtask

  task automatic test_basic();
    bus_write(ADDR_CMP, 16'h0010);
    bus_write(ADDR_CTRL, 16'h0001);
    n_cmp++; if (TIMER_INT_VALUE !== 16'h0010) begin
      n_err++; $display("FAIL basic_cmp: TIMER_INT_VALUE=%h required 0010", TIMER_INT_VALUE); end
    TPUINT = 1'b1;
    tick();
    m_evt++;
    n_cmp++; if ({IRQ, INTFLAG} !== 2'b11) begin
      n_err++; $display("FAIL basic_irq: IRQ/INTFLAG=%b required 11", {IRQ, INTFLAG}); end
    bus_read(ADDR_STATUS, status(1'b1, m_evt), "basic_pend");
    IACK = 1'b1;
    tick();
    IACK = 1'b0;
    n_cmp++; if ({IRQ, INTFLAG} !== 2'b00) begin
      n_err++; $display("FAIL basic_ack: IRQ/INTFLAG=%b required 00", {IRQ, INTFLAG}); end
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "basic_drain");
    TPUINT = 1'b0;
    tick();
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "basic_idle");
  endtask

  task automatic test_rsttpu();
    bus_write(ADDR_CTRL, 16'h0005);
    n_cmp++; if ({RSTTPU, TIMERINTMSK} !== 2'b11) begin
      n_err++; $display("FAIL rsttpu_hi: RSTTPU/MSK=%b required 11", {RSTTPU, TIMERINTMSK}); end
    tick();
    n_cmp++; if ({RSTTPU, IRQ} !== 2'b00) begin
      n_err++; $display("FAIL rsttpu_lo: RSTTPU/IRQ=%b required 00", {RSTTPU, IRQ}); end
    bus_read(ADDR_CTRL, 16'h0001, "rsttpu_rd_ctrl");
  endtask

  task automatic test_periodic();
    bus_write(ADDR_CTRL, 16'h0003);
    bus_write(ADDR_CMP, 16'd100);
    bus_write(ADDR_PERIOD, 16'd300);
    m_cmp = 16'd100;
    for (int i = 0; i < 3; i++) begin
      ack_event(i[0]);
      m_evt++;
      m_cmp = m_cmp + 16'd300;
      n_cmp++; if (TIMER_INT_VALUE !== m_cmp) begin
        n_err++; $display("FAIL periodic_%0d: TIMER_INT_VALUE=%0d required %0d", i, TIMER_INT_VALUE, m_cmp); end
    end
    bus_write(ADDR_CMP, 16'd65000);
    bus_write(ADDR_PERIOD, 16'd1000);
    ack_event(1'b0);
    m_evt++;
    m_cmp = 16'd65000 + 16'd1000;
    n_cmp++; if (TIMER_INT_VALUE !== m_cmp) begin
      n_err++; $display("FAIL periodic_wrap: TIMER_INT_VALUE=%0d required %0d", TIMER_INT_VALUE, m_cmp); end
    TPUINT = 1'b1;
    bus_write(ADDR_CMP, 16'h1234);
    m_evt++;
    n_cmp++; if ({IRQ, TIMER_INT_VALUE} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL periodic_collide: IRQ=%b CMP=%h required 1 1234", IRQ, TIMER_INT_VALUE); end
    IACK = 1'b1; tick(); IACK = 1'b0;
    TPUINT = 1'b0; tick();
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "periodic_evt");
    bus_write(ADDR_CTRL, 16'h0001);
  endtask

  task automatic test_mask();
    int n;
    bus_write(ADDR_CTRL, 16'h0000);
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      TPUINT = 1'b1; tick();
      n_cmp++; if (IRQ !== 1'b0) begin
        n_err++; $display("FAIL mask_off_%0d: IRQ=%b required 0", i, IRQ); end
      TPUINT = 1'b0; tick();
    end
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "mask_off_evt");
    bus_write(ADDR_CTRL, 16'h0001);
    TPUINT = 1'b1; tick();
    m_evt++;
    n_cmp++; if (IRQ !== 1'b1) begin
      n_err++; $display("FAIL mask_pend: IRQ=%b required 1", IRQ); end
    bus_write(ADDR_CTRL, 16'h0000);
    n_cmp++; if ({IRQ, INTFLAG} !== 2'b00) begin
      n_err++; $display("FAIL mask_clr: IRQ/INTFLAG=%b required 00", {IRQ, INTFLAG}); end
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "mask_clr_evt");
    TPUINT = 1'b0; tick();
    bus_write(ADDR_CTRL, 16'h0001);
    TPUINT = 1'b1;
    bus_write(ADDR_CTRL, 16'h0000);
    tick();
    n_cmp++; if (IRQ !== 1'b0) begin
      n_err++; $display("FAIL mask_same_cycle: IRQ=%b required 0", IRQ); end
    TPUINT = 1'b0; tick();
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "mask_same_evt");
    bus_write(ADDR_CTRL, 16'h0001);
  endtask

  task automatic test_drain();
    TPUINT = 1'b1; tick();
    m_evt++;
    TPUINT = 1'b0; IACK = 1'b1; tick(); IACK = 1'b0;
    TPUINT = 1'b1; tick();
    n_cmp++; if (IRQ !== 1'b0) begin
      n_err++; $display("FAIL drain_rise: IRQ=%b required 0", IRQ); end
    IACK = 1'b1; tick(); IACK = 1'b0;
    n_cmp++; if (INTFLAG !== 1'b0) begin
      n_err++; $display("FAIL drain_iack: INTFLAG=%b required 0", INTFLAG); end
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "drain_evt");
    TPUINT = 1'b0; tick();
    TPUINT = 1'b1; tick();
    m_evt++;
    n_cmp++; if (IRQ !== 1'b1) begin
      n_err++; $display("FAIL drain_exit: IRQ=%b required 1", IRQ); end
    IACK = 1'b1; tick(); IACK = 1'b0;
    TPUINT = 1'b0; tick();
  endtask

  task automatic test_clear();
    TPUINT = 1'b1;
    bus_write(ADDR_STATUS, 16'h0001);
    m_evt = 8'd0;
    n_cmp++; if (IRQ !== 1'b1) begin
      n_err++; $display("FAIL clear_take: IRQ=%b required 1", IRQ); end
    bus_read(ADDR_STATUS, status(1'b1, m_evt), "clear_wins");
    IACK = 1'b1; tick(); IACK = 1'b0;
    TPUINT = 1'b0; tick();
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "clear_idle");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 255; i++) begin
      ack_event(i[0]);
      m_evt++;
    end
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "wrap_255");
    ack_event(1'b0);
    m_evt++;
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "wrap_0");
  endtask

  task automatic test_async_reset();
    TPUINT = 1'b1; tick();
    n_cmp++; if (IRQ !== 1'b1) begin
      n_err++; $display("FAIL arst_pend: IRQ=%b required 1", IRQ); end
    #2 RST = 1'b1;
    #1;
    n_cmp++; if ({IRQ, INTFLAG, TIMERINTMSK} !== 3'b000) begin
      n_err++; $display("FAIL arst_drop: IRQ/INTFLAG/MSK=%b required 000", {IRQ, INTFLAG, TIMERINTMSK}); end
    TPUINT = 1'b0;
    @(negedge SYS_CLK);
    RST = 1'b0;
    m_evt = 8'd0;
    tick();
    bus_read(ADDR_CTRL, 16'h0000, "arst_rd_ctrl");
    bus_read(ADDR_STATUS, status(1'b0, m_evt), "arst_rd_status");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rsttpu();
    test_periodic();
    test_mask();
    test_drain();
    test_clear();
    test_wrap();
    test_async_reset();
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rd_drain: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
